// File: rtl/rr_mux_if.sv
// Handshake bundle between N requesters, the merge register and the downstream sink.
// The slave view belongs to the merger; the master view drives requests and out_ready.
interface rr_mux_if #(
   parameter int N = 4,
   parameter int W = 8
);
   localparam int S = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [S-1:0]   out_sel;
   logic           out_ready;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/rr_mux.sv
// Round-robin merge of N valid/ready request streams into one registered output word.
// The channel after the last granted one holds top priority for the next grant.
module rr_mux #(
   parameter int N = 4,
   parameter int W = 8
) (
   input logic     clk,
   input logic     rstn,
   input logic     en,
   rr_mux_if.slave bus
);
   localparam int S = (N > 1) ? $clog2(N) : 1;

   logic         r_vld_p1;
   logic [W-1:0] r_data_p1;
   logic [S-1:0] r_sel_p1;
   logic [S-1:0] r_ptr;

   logic         w_load;
   logic         w_found;
   logic         w_xfer;
   logic [S-1:0] w_idx;
   logic [S-1:0] w_gidx;
   logic [S-1:0] w_ptr_nxt;
   logic [N-1:0] w_grant;
   logic [W-1:0] w_data;

   function automatic logic [S-1:0] f_wrap_inc(input logic [S-1:0] idx);
      if (int'(idx) >= N - 1) return '0;
      return idx + 1'b1;
   endfunction

   // rstn gating keeps in_ready silent while reset is held, even with an empty register.
   assign w_load = rstn & en & (~r_vld_p1 | bus.out_ready);

   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_idx   = r_ptr;
      for (int k = 0; k < N; k++) begin
         if (!w_found && bus.in_valid[w_idx]) begin
            w_found = 1'b1;
            w_gidx  = w_idx;
         end
         w_idx = f_wrap_inc(w_idx);
      end
   end

   assign w_xfer    = w_load & w_found;
   assign w_ptr_nxt = f_wrap_inc(w_gidx);

   always_comb begin
      w_grant = '0;
      if (w_xfer) w_grant[w_gidx] = 1'b1;
   end

   always_comb begin
      w_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_gidx == S'(i)) w_data = bus.in_data[i*W +: W];
      end
   end

   // Stage p0 -> p1: single-entry output register, refilled in the same cycle it drains.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_vld_p1  <= 1'b0;
         r_data_p1 <= '0;
         r_sel_p1  <= '0;
         r_ptr     <= '0;
      end else if (w_xfer) begin
         r_vld_p1  <= 1'b1;
         r_data_p1 <= w_data;
         r_sel_p1  <= w_gidx;
         r_ptr     <= w_ptr_nxt;
      end else if (bus.out_ready) begin
         r_vld_p1  <= 1'b0;
      end
   end

   assign bus.in_ready  = w_grant;
   assign bus.out_valid = r_vld_p1;
   assign bus.out_data  = r_data_p1;
   assign bus.out_sel   = r_sel_p1;
endmodule

// File: tb/tb_rr_mux.sv
// Scenario bench for rr_mux (N=4, W=8): a queue of expected words is filled when a grant
// is predicted and drained as the output register is consumed.
module tb_rr_mux;
   localparam int N = 4;
   localparam int W = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   logic en   = 1'b0;

   always #5 clk = ~clk;

   rr_mux_if #(.N(N), .W(W)) bus ();
   rr_mux #(.N(N), .W(W)) dut (.clk(clk), .rstn(rstn), .en(en), .bus(bus));

   int         n_chk  = 0;
   int         n_fail = 0;
   int         m_ptr  = 0;
   logic       m_vld  = 1'b0;
   logic [9:0] sb_q[$];

   function automatic int exp_grant(input logic [3:0] v, input logic e, input logic o);
      if (!(e && (!m_vld || o))) return -1;
      for (int k = 0; k < N; k++) begin
         if (((v >> ((m_ptr + k) % N)) & 4'b0001) != 4'b0000) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [3:0] rdy_of(input int g);
      if (g < 0) return 4'b0000;
      return 4'b0001 << g;
   endfunction

   task automatic sb_update(input int g, input logic o, input logic [31:0] d);
      if (m_vld && o && sb_q.size() > 0) void'(sb_q.pop_front());
      if (g >= 0) begin
         sb_q.push_back({2'(g), 8'(d >> (8 * g))});
         m_ptr = (g + 1) % N;
         m_vld = 1'b1;
      end else if (o) begin
         m_vld = 1'b0;
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic o, input logic e);
      @(posedge clk);
      #1;
      bus.in_valid  = v;
      bus.in_data   = d;
      bus.out_ready = o;
      en            = e;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.in_valid  = 4'b1111;
      bus.in_data   = 32'hDEAD_BEEF;
      bus.out_ready = 1'b1;
      en            = 1'b1;
      #12;
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_chk++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", bus.out_data); end
      n_chk++; if (bus.out_sel !== 2'd0) begin n_fail++; $display("FAIL reset_out_sel: got %0d want 0", bus.out_sel); end
      n_chk++; if (bus.in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0000", bus.in_ready); end
      bus.in_valid = 4'b0000;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_single();
      logic [3:0]  v;
      logic [31:0] d;
      int          g;
      for (int c = 0; c < 2; c++) begin
         v = (c == 0) ? 4'b0100 : 4'b0000;
         d = (c == 0) ? 32'h00A5_0000 : 32'h0;
         drive(v, d, 1'b1, 1'b1);
         g = exp_grant(v, 1'b1, 1'b1);
         n_chk++; if (bus.in_ready !== rdy_of(g)) begin n_fail++; $display("FAIL single_in_ready c%0d: got %b want %b", c, bus.in_ready, rdy_of(g)); end
         n_chk++; if (bus.out_valid !== m_vld) begin n_fail++; $display("FAIL single_out_valid c%0d: got %b want %b", c, bus.out_valid, m_vld); end
         if (m_vld && sb_q.size() > 0) begin
            n_chk++; if ({bus.out_sel, bus.out_data} !== sb_q[0]) begin n_fail++; $display("FAIL single_word c%0d: got %h want %h", c, {bus.out_sel, bus.out_data}, sb_q[0]); end
         end
         if (c == 0) begin
            n_chk++; if (bus.in_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant2: got %b want 0100", bus.in_ready); end
         end else begin
            n_chk++; if ({bus.out_valid, bus.out_sel, bus.out_data} !== {1'b1, 2'd2, 8'hA5}) begin n_fail++; $display("FAIL single_out: got v=%b sel=%0d data=%h want v=1 sel=2 data=a5", bus.out_valid, bus.out_sel, bus.out_data); end
         end
         sb_update(g, 1'b1, d);
      end
   endtask

   task automatic test_round_robin();
      int          want_sel[5] = '{0, 1, 2, 3, 0};
      logic [3:0]  v;
      logic [31:0] d;
      int          g;
      for (int c = 0; c < 7; c++) begin
         v = (c == 0) ? 4'b1000 : ((c == 6) ? 4'b0000 : 4'b1111);
         d = $urandom;
         drive(v, d, 1'b1, 1'b1);
         g = exp_grant(v, 1'b1, 1'b1);
         n_chk++; if (bus.in_ready !== rdy_of(g)) begin n_fail++; $display("FAIL rr_in_ready c%0d: got %b want %b", c, bus.in_ready, rdy_of(g)); end
         n_chk++; if (bus.out_valid !== m_vld) begin n_fail++; $display("FAIL rr_out_valid c%0d: got %b want %b", c, bus.out_valid, m_vld); end
         if (m_vld && sb_q.size() > 0) begin
            n_chk++; if ({bus.out_sel, bus.out_data} !== sb_q[0]) begin n_fail++; $display("FAIL rr_word c%0d: got %h want %h", c, {bus.out_sel, bus.out_data}, sb_q[0]); end
         end
         if (c >= 2) begin
            n_chk++; if ({bus.out_valid, bus.out_sel} !== {1'b1, 2'(want_sel[c-2])}) begin n_fail++; $display("FAIL rr_sequence c%0d: got v=%b sel=%0d want v=1 sel=%0d", c, bus.out_valid, bus.out_sel, want_sel[c-2]); end
         end
         sb_update(g, 1'b1, d);
      end
   endtask

   task automatic test_backpressure();
      logic [3:0]  v;
      logic [31:0] d;
      logic        o;
      int          g;
      for (int c = 0; c < 8; c++) begin
         v = (c == 0) ? 4'b0001 : ((c == 7) ? 4'b0000 : 4'b1111);
         d = (c == 0) ? 32'h0000_003C : $urandom;
         o = (c >= 6);
         drive(v, d, o, 1'b1);
         g = exp_grant(v, 1'b1, o);
         n_chk++; if (bus.in_ready !== rdy_of(g)) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b want %b", c, bus.in_ready, rdy_of(g)); end
         n_chk++; if (bus.out_valid !== m_vld) begin n_fail++; $display("FAIL bp_out_valid c%0d: got %b want %b", c, bus.out_valid, m_vld); end
         if (m_vld && sb_q.size() > 0) begin
            n_chk++; if ({bus.out_sel, bus.out_data} !== sb_q[0]) begin n_fail++; $display("FAIL bp_word c%0d: got %h want %h", c, {bus.out_sel, bus.out_data}, sb_q[0]); end
         end
         if (c >= 1 && c <= 5) begin
            n_chk++; if ({bus.in_ready, bus.out_sel, bus.out_data} !== {4'b0000, 2'd0, 8'h3C}) begin n_fail++; $display("FAIL bp_hold c%0d: got rdy=%b sel=%0d data=%h want rdy=0000 sel=0 data=3c", c, bus.in_ready, bus.out_sel, bus.out_data); end
         end
         if (c == 6) begin
            n_chk++; if (bus.in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release: got %b want 0010", bus.in_ready); end
         end
         sb_update(g, o, d);
      end
   endtask

   task automatic test_enable();
      logic [3:0]  v;
      logic [31:0] d;
      logic        o;
      logic        e;
      int          g;
      for (int c = 0; c < 6; c++) begin
         v = (c == 5) ? 4'b0000 : 4'b0001;
         d = (c == 0) ? 32'h0000_005A : $urandom;
         o = (c >= 2);
         e = (c == 0 || c >= 4);
         drive(v, d, o, e);
         g = exp_grant(v, e, o);
         n_chk++; if (bus.in_ready !== rdy_of(g)) begin n_fail++; $display("FAIL en_in_ready c%0d: got %b want %b", c, bus.in_ready, rdy_of(g)); end
         n_chk++; if (bus.out_valid !== m_vld) begin n_fail++; $display("FAIL en_out_valid c%0d: got %b want %b", c, bus.out_valid, m_vld); end
         if (m_vld && sb_q.size() > 0) begin
            n_chk++; if ({bus.out_sel, bus.out_data} !== sb_q[0]) begin n_fail++; $display("FAIL en_word c%0d: got %h want %h", c, {bus.out_sel, bus.out_data}, sb_q[0]); end
         end
         if (c == 3) begin
            n_chk++; if ({bus.out_valid, bus.in_ready} !== 5'b0_0000) begin n_fail++; $display("FAIL en_idle: got v=%b rdy=%b want v=0 rdy=0000", bus.out_valid, bus.in_ready); end
         end
         if (c == 4) begin
            n_chk++; if (bus.in_ready !== 4'b0001) begin n_fail++; $display("FAIL en_resume: got %b want 0001", bus.in_ready); end
         end
         sb_update(g, o, d);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      int          g;
      d = $urandom;
      drive(4'b1111, d, 1'b0, 1'b1);
      g = exp_grant(4'b1111, 1'b1, 1'b0);
      n_chk++; if (bus.in_ready !== rdy_of(g)) begin n_fail++; $display("FAIL rmid_in_ready: got %b want %b", bus.in_ready, rdy_of(g)); end
      sb_update(g, 1'b0, d);
      @(posedge clk);
      #2;
      n_chk++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_held: got %b want 1", bus.out_valid); end
      bus.in_valid  = 4'b1010;
      bus.out_ready = 1'b1;
      rstn = 1'b0;
      #1;
      n_chk++; if ({bus.out_valid, bus.out_sel, bus.out_data, bus.in_ready} !== 15'h0) begin n_fail++; $display("FAIL rmid_clear: got v=%b sel=%0d data=%h rdy=%b want all zero", bus.out_valid, bus.out_sel, bus.out_data, bus.in_ready); end
      m_vld = 1'b0;
      m_ptr = 0;
      sb_q.delete();
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      g = exp_grant(bus.in_valid, 1'b1, 1'b1);
      n_chk++; if (bus.in_ready !== 4'b0010 || bus.in_ready !== rdy_of(g)) begin n_fail++; $display("FAIL rmid_first_grant: got %b want 0010", bus.in_ready); end
      sb_update(g, 1'b1, bus.in_data);
      drive(4'b0000, 32'h0, 1'b1, 1'b1);
      n_chk++; if (bus.out_valid !== 1'b1 || sb_q.size() == 0 || {bus.out_sel, bus.out_data} !== sb_q[0]) begin n_fail++; $display("FAIL rmid_word: got v=%b sel=%0d data=%h", bus.out_valid, bus.out_sel, bus.out_data); end
      n_chk++; if (bus.out_sel !== 2'd1) begin n_fail++; $display("FAIL rmid_sel: got %0d want 1", bus.out_sel); end
      sb_update(-1, 1'b1, 32'h0);
   endtask

   task automatic test_wrap();
      logic [3:0]  v;
      logic [31:0] d;
      int          g;
      for (int c = 0; c < 3; c++) begin
         v = (c == 0) ? 4'b1000 : ((c == 1) ? 4'b1001 : 4'b0000);
         d = $urandom;
         drive(v, d, 1'b1, 1'b1);
         g = exp_grant(v, 1'b1, 1'b1);
         n_chk++; if (bus.in_ready !== rdy_of(g)) begin n_fail++; $display("FAIL wrap_in_ready c%0d: got %b want %b", c, bus.in_ready, rdy_of(g)); end
         n_chk++; if (bus.out_valid !== m_vld) begin n_fail++; $display("FAIL wrap_out_valid c%0d: got %b want %b", c, bus.out_valid, m_vld); end
         if (m_vld && sb_q.size() > 0) begin
            n_chk++; if ({bus.out_sel, bus.out_data} !== sb_q[0]) begin n_fail++; $display("FAIL wrap_word c%0d: got %h want %h", c, {bus.out_sel, bus.out_data}, sb_q[0]); end
         end
         if (c == 1) begin
            n_chk++; if ({bus.in_ready, bus.out_sel} !== {4'b0001, 2'd3}) begin n_fail++; $display("FAIL wrap_grant0: got rdy=%b sel=%0d want rdy=0001 sel=3", bus.in_ready, bus.out_sel); end
         end
         if (c == 2) begin
            n_chk++; if (bus.out_sel !== 2'd0) begin n_fail++; $display("FAIL wrap_sel: got %0d want 0", bus.out_sel); end
         end
         sb_update(g, 1'b1, d);
      end
   endtask

   initial begin
      bus.in_valid  = 4'b0000;
      bus.in_data   = 32'h0;
      bus.out_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_enable();
      test_reset_mid();
      test_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1);
   end
endmodule

// File: doc/rr_mux.md
RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (N >= 1).
REQ-002 SHALL have parameter W, default 8, data width per channel.
REQ-003 SHALL define S = max(1, clog2(N)), the width of the channel-select field.
REQ-004 SHALL have port clk  input  1  the only clock; all state updates on rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  block enable; gates acceptance of new input words.
REQ-007 SHALL have port in_valid  input  N  per-channel request; bit i is channel i.
REQ-008 SHALL have port in_data  input  N*W  channel i data occupies bits [i*W +: W].
REQ-009 SHALL have port in_ready  output  N  per-channel accept; at most one bit set.
REQ-010 SHALL have port out_valid  output  1  output register holds a word.
REQ-011 SHALL have port out_data  output  W  registered merged data.
REQ-012 SHALL have port out_sel  output  S  index of the channel that supplied out_data.
REQ-013 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-014 SHALL merge N requester streams onto one output; a single-entry output register gives 1-cycle latency.
REQ-015 SHALL maintain an internal round-robin pointer ptr (width S) naming the highest-priority channel.
REQ-016 SHALL define load = en & (!out_valid | out_ready).
REQ-017 SHALL grant when load=1: search channels ptr, ptr+1, ... mod N; the first with in_valid set is granted; in_ready is one-hot for the granted channel and zero otherwise.
REQ-018 SHALL drive in_ready combinationally from in_valid, ptr, out_valid, out_ready, en; in_ready SHALL be all-zero when load=0 or no in_valid bit is set.
REQ-019 SHALL on transfer (in_valid[g] & in_ready[g]) set, at the next edge, out_valid=1, out_data=in_data[g], out_sel=g, ptr=(g+1) mod N.
REQ-020 SHALL on out_valid & out_ready with no transfer clear out_valid at the next edge; out_data and out_sel hold their last values.
REQ-021 SHALL on simultaneous drain and transfer load the new word with out_valid remaining 1 (one word per cycle sustained).
REQ-022 SHALL keep out_data and out_sel stable while out_valid & !out_ready (backpressure).
REQ-023 SHALL leave ptr unchanged in any cycle without a transfer.
REQ-024 SHALL, when en=0, accept nothing (in_ready=0) while still presenting and draining a held word; ptr holds.
REQ-025 SHALL, for N=1, always grant channel 0; out_sel constant 0.
REQ-026 SHALL grant no channel for more than one consecutive transfer while another channel requests continuously (starvation-free: max wait N-1 transfers).

Reset
REQ-027 SHALL, on rstn low, asynchronously force out_valid=0, out_data=0, out_sel=0, ptr=0, in_ready=0.
REQ-028 SHALL discard any held output word when reset asserts mid-operation; no word is emitted after release until a new transfer.
REQ-029 SHALL begin arbitration on the first rising edge after rstn deasserts, with channel 0 highest priority.

Verification (N=4, W=8)
REQ-030 SHALL cover: reset, then in_valid=4'b0100, in_data[23:16]=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_valid=1, out_data=8'hA5, out_sel=2.
REQ-031 SHALL cover: all in_valid=4'b1111 held, out_ready=1, ptr=0 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
REQ-032 SHALL cover: out_valid=1, out_data=8'h3C, out_ready=0 for 5 cycles with requests pending -> in_ready=0, out_data=8'h3C and out_sel unchanged; on out_ready=1, next word loads in the same cycle.
REQ-033 SHALL cover: en=0 with in_valid=4'b0001 and held word -> held word drains on out_ready=1, then out_valid=0, in_ready=0; en=1 -> channel 0 granted.
REQ-034 SHALL cover: rstn pulsed low mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_sel=0 immediately (without clock); after release with in_valid=4'b1010, channel 1 granted first.
REQ-035 SHALL cover: after grant to channel 3, in_valid=4'b1001 -> channel 0 granted next (wrap-around).
